// File: rtl/bec_la_pkg.sv
// Shared encodings for the BEC logic-analyzer command bridge.
// Holds command codes, LA bit positions, status codes and address windows.
// No logic; imported by the interface, synchronizer and bridge.
package bec_la_pkg;

  localparam int OP_WORDS  = 12;
  localparam int RES_WORDS = 12;
  localparam int LA_W      = 128;
  localparam int IO_W      = 38;

  // LA bit positions (command on la_data_in, response on la_data_out)
  localparam int LA_WDATA_LSB = 0;
  localparam int LA_ADDR_LSB  = 32;
  localparam int LA_CMD_LSB   = 40;
  localparam int LA_REQ_BIT   = 64;

  typedef enum logic [1:0] {
    CMD_NOP   = 2'b00,
    CMD_WRITE = 2'b01,
    CMD_START = 2'b10,
    CMD_READ  = 2'b11
  } cmd_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  typedef struct packed {
    cmd_e        kind;
    logic [7:0]  addr;
    logic [31:0] wdata;
  } la_cmd_t;

  // Bench-visible status codes
  localparam logic [15:0] ST_RESET   = 16'hAB30;
  localparam logic [15:0] ST_WR_OK   = 16'hAB41;
  localparam logic [15:0] ST_STARTED = 16'hAB42;
  localparam logic [15:0] ST_WR_ERR  = 16'hAB44;
  localparam logic [15:0] ST_DONE    = 16'hAB51;

  localparam logic [31:0] BAD_RDATA = 32'hDEADBEEF;
  localparam logic [7:0]  OP_LIMIT  = 8'(OP_WORDS);
  localparam logic [7:0]  RES_BASE  = 8'h80;
  localparam logic [7:0]  RES_LIMIT = RES_BASE + 8'(RES_WORDS);

  // Pull the command fields out of the low LA word
  function automatic la_cmd_t la_decode(input logic [41:0] d);
    la_cmd_t r;
    r.kind  = cmd_e'(d[LA_CMD_LSB +: 2]);
    r.addr  = d[LA_ADDR_LSB +: 8];
    r.wdata = d[LA_WDATA_LSB +: 32];
    return r;
  endfunction

endpackage

// File: rtl/bec_la_bridge_if.sv
// Bundles the LA probe, BEC core and status pad signals of the bridge.
// Pure wiring, no latency.
// No backpressure; the LA side uses a req/ack toggle handshake.
interface bec_la_bridge_if;
  import bec_la_pkg::*;

  logic [LA_W-1:0]           la_data_in;
  logic [LA_W-1:0]           la_oenb;
  logic [LA_W-1:0]           la_data_out;
  logic [OP_WORDS*32-1:0]    core_op;
  logic                      core_start;
  logic                      core_done;
  logic [RES_WORDS*32-1:0]   core_res;
  logic [IO_W-1:0]           io_out;
  logic [IO_W-1:0]           io_oeb;

  // Management / test side
  modport master (
    output la_data_in, la_oenb, core_done, core_res,
    input  la_data_out, core_op, core_start, io_out, io_oeb
  );

  // Bridge side
  modport slave (
    input  la_data_in, la_oenb, core_done, core_res,
    output la_data_out, core_op, core_start, io_out, io_oeb
  );

endinterface

// File: rtl/bec_la_sync.sv
// Two-flop synchronizer for the LA req toggle with a registered change pulse.
// Latency: a change before edge k gives pulse high in the cycle after edge k+2.
// No backpressure; toggles closer than the sync depth may merge.
module bec_la_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);

  logic s1, s2, req_prev;

  // Resynchronize the toggle and flag each change exactly once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      req_prev <= 1'b0;
      pulse    <= 1'b0;
    end else begin
      s1       <= d;
      s2       <= s1;
      req_prev <= s2;
      pulse    <= s2 ^ req_prev;
    end
  end

endmodule

// File: rtl/bec_la_bridge.sv
// LA command responder for the BEC core: WRITE/START/READ over a req/ack toggle.
// Latency: req change before edge k -> ack, data, err and core_start update at edge k+3.
// No backpressure; every detected command is acked once. Status pads: BEC_STATUS_IO_EN.
module bec_la_bridge
  import bec_la_pkg::*;
(
  input  logic           wb_clk_i,
  input  logic           wb_rst_i,
  bec_la_bridge_if.slave bus
);

  la_cmd_t                    c;
  logic                       req_pulse, cmd_vld;
  state_e                     state_q, state_d;
  logic [OP_WORDS-1:0][31:0]  op_q;
  logic [RES_WORDS-1:0][31:0] res_q;
  logic [31:0]                rdata_q, rdata_d;
  logic                       ack_q, done_q, done_d, err_q, err_d;
  logic                       start_q, start_d;
  logic                       wr_en, res_ld, cmd_ok, stat_ld;
  logic [15:0]                stat_d;

  bec_la_sync u_sync (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .d     (bus.la_data_in[LA_REQ_BIT]),
    .pulse (req_pulse)
  );

  assign c       = la_decode(bus.la_data_in[41:0]);
  assign cmd_vld = req_pulse & ~bus.la_oenb[LA_REQ_BIT];

  // Completion is applied first; the command is judged against the current
  // state, so a same-cycle rejected START still sees BUSY and a READ of the
  // result returns the pre-latch value. Command status overrides done status.
  always_comb begin
    state_d = state_q;
    done_d  = done_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    start_d = 1'b0;
    wr_en   = 1'b0;
    res_ld  = 1'b0;
    cmd_ok  = 1'b0;
    stat_ld = 1'b0;
    stat_d  = ST_RESET;
    if ((state_q == ST_BUSY) && bus.core_done) begin
      state_d = ST_IDLE;
      done_d  = 1'b1;
      res_ld  = 1'b1;
      stat_ld = 1'b1;
      stat_d  = ST_DONE;
    end
    if (cmd_vld) begin
      case (c.kind)
        CMD_NOP: begin
          err_d  = 1'b0;
          cmd_ok = 1'b1;
        end
        CMD_WRITE: begin
          stat_ld = 1'b1;
          if ((c.addr < OP_LIMIT) && (state_q == ST_IDLE)) begin
            wr_en  = 1'b1;
            err_d  = 1'b0;
            cmd_ok = 1'b1;
            stat_d = ST_WR_OK;
          end else begin
            err_d  = 1'b1;
            stat_d = ST_WR_ERR;
          end
        end
        CMD_START: begin
          if (state_q == ST_IDLE) begin
            start_d = 1'b1;
            state_d = ST_BUSY;
            done_d  = 1'b0;
            err_d   = 1'b0;
            cmd_ok  = 1'b1;
            stat_ld = 1'b1;
            stat_d  = ST_STARTED;
          end else begin
            err_d = 1'b1;
          end
        end
        CMD_READ: begin
          if (c.addr < OP_LIMIT) begin
            rdata_d = op_q[c.addr[3:0]];
            err_d   = 1'b0;
            cmd_ok  = 1'b1;
          end else if ((c.addr >= RES_BASE) && (c.addr < RES_LIMIT)) begin
            rdata_d = res_q[c.addr[3:0]];
            err_d   = 1'b0;
            cmd_ok  = 1'b1;
          end else begin
            rdata_d = BAD_RDATA;
            err_d   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Operand/result buffers and LA response registers
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      op_q    <= '0;
      res_q   <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
    end else begin
      if (wr_en)  op_q[c.addr[3:0]] <= c.wdata;
      if (res_ld) res_q <= bus.core_res;
      rdata_q <= rdata_d;
      ack_q   <= ack_q ^ cmd_vld;
      done_q  <= done_d;
      err_q   <= err_d;
      start_q <= start_d;
    end
  end

  assign bus.la_data_out = {60'b0, err_q, done_q, (state_q == ST_BUSY), ack_q, 32'b0, rdata_q};
  assign bus.core_op     = op_q;
  assign bus.core_start  = start_q;

`ifdef BEC_STATUS_IO_EN
  logic [15:0] status_q;
  logic [7:0]  cnt_q;

  // Status code and accepted-command counter for the pads
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      status_q <= ST_RESET;
      cnt_q    <= 8'h00;
    end else begin
      if (stat_ld) status_q <= stat_d;
      if (cmd_ok)  cnt_q    <= cnt_q + 8'd1;
    end
  end

  assign bus.io_out = {6'b0, status_q, cnt_q, 8'b0};
  assign bus.io_oeb = {6'h3F, 24'h0, 8'hFF};
`else
  logic unused_status;
  assign unused_status = ^{stat_ld, stat_d, cmd_ok};
  assign bus.io_out    = '0;
  assign bus.io_oeb    = '1;
`endif

  logic unused_la;
  assign unused_la = ^{bus.la_data_in[127:65], bus.la_data_in[63:42],
                       bus.la_oenb[127:65], bus.la_oenb[63:0]};

endmodule

// File: tb/tb_bec_la_bridge.sv
// Self-checking bench for bec_la_bridge: vector table, corner sequences, random commands.
// Latency: expects ack on the 4th falling edge after the req toggle.
// No backpressure; commands issued back to back as soon as ack is seen.
module tb_bec_la_bridge;
  import bec_la_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bec_la_bridge_if bus();
  bec_la_bridge dut (.wb_clk_i(clk), .wb_rst_i(rst), .bus(bus));

  int checks = 0;
  int failures = 0;
  int start_cnt = 0;
  int m_starts = 0;

  // Reference model state
  logic [31:0] m_op [OP_WORDS];
  logic [31:0] m_res [RES_WORDS];
  logic [31:0] res_vec [RES_WORDS];
  logic        m_busy, m_done, m_err, m_ack, req, exp_start;
  logic [31:0] m_rdata;
  logic [15:0] m_stat;
  logic [7:0]  m_cnt;

  typedef struct {
    logic [1:0]  k;
    logic [7:0]  a;
    logic [31:0] wd;
    logic        dn;
    logic [31:0] rd;
    logic        er, bz, dq;
  } vec_t;
  vec_t tbl [14];

  always @(negedge clk) if (bus.core_start === 1'b1) start_cnt++;

  task automatic chk(input string name, input logic [383:0] act, input logic [383:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [383:0] pack_op();
    logic [383:0] r;
    for (int i = 0; i < OP_WORDS; i++) r[i*32 +: 32] = m_op[i];
    return r;
  endfunction

  function automatic logic [383:0] pack_resvec();
    logic [383:0] r;
    for (int i = 0; i < RES_WORDS; i++) r[i*32 +: 32] = res_vec[i];
    return r;
  endfunction

  function automatic logic [127:0] model_la();
    return {60'b0, m_err, m_done, m_busy, m_ack, 32'b0, m_rdata};
  endfunction

  function automatic logic [37:0] model_io();
`ifdef BEC_STATUS_IO_EN
    return {6'b0, m_stat, m_cnt, 8'b0};
`else
    return '0;
`endif
  endfunction

  function automatic logic [37:0] model_oeb();
`ifdef BEC_STATUS_IO_EN
    return {6'h3F, 24'h0, 8'hFF};
`else
    return '1;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < OP_WORDS; i++) m_op[i] = '0;
    for (int i = 0; i < RES_WORDS; i++) m_res[i] = '0;
    m_busy = 0; m_done = 0; m_err = 0; m_ack = 0; m_rdata = '0;
    m_stat = 16'hAB30; m_cnt = 8'h00; req = 0;
  endtask

  task automatic drive_idle();
    bus.la_data_in = '0;
    bus.la_oenb    = '0;
    bus.core_done  = 1'b0;
    bus.core_res   = '0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, " la_data_out"}, bus.la_data_out, model_la());
    chk({tag, " core_op"}, bus.core_op, pack_op());
    chk({tag, " io_out"}, bus.io_out, model_io());
    chk({tag, " io_oeb"}, bus.io_oeb, model_oeb());
  endtask

  task automatic rand_res();
    for (int i = 0; i < RES_WORDS; i++) res_vec[i] = $urandom;
  endtask

  // Issue one command (called at a falling edge); optionally pulse core_done
  // in the cycle the command is acted on.
  task automatic do_cmd(input logic [1:0] k, input logic [7:0] a, input logic [31:0] wd,
                        input logic with_done, input string tag);
    logic pre_busy, acc;
    int   lat;
    bus.la_data_in[31:0]  = wd;
    bus.la_data_in[39:32] = a;
    bus.la_data_in[41:40] = k;
    req = ~req;
    bus.la_data_in[64] = req;

    pre_busy = m_busy; acc = 0; exp_start = 0;
    if (with_done && pre_busy) begin
      m_busy = 0; m_done = 1; m_stat = 16'hAB51;
    end
    case (k)
      2'd0: begin m_err = 0; acc = 1; end
      2'd1: if (a < 12 && !pre_busy) begin
              m_op[a] = wd; m_err = 0; m_stat = 16'hAB41; acc = 1;
            end else begin
              m_err = 1; m_stat = 16'hAB44;
            end
      2'd2: if (!pre_busy) begin
              exp_start = 1; m_starts++; m_busy = 1; m_done = 0; m_err = 0;
              m_stat = 16'hAB42; acc = 1;
            end else m_err = 1;
      default: if (a < 12) begin
                 m_rdata = m_op[a]; m_err = 0; acc = 1;
               end else if (a >= 8'h80 && a < 8'h8C) begin
                 m_rdata = m_res[a - 8'h80]; m_err = 0; acc = 1;
               end else begin
                 m_rdata = 32'hDEADBEEF; m_err = 1;
               end
    endcase
    if (with_done && pre_busy) for (int i = 0; i < RES_WORDS; i++) m_res[i] = res_vec[i];
    if (acc) m_cnt++;
    m_ack = ~m_ack;

    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 4) bus.core_done = 1'b0;
      if (bus.la_data_out[64] === m_ack) begin lat = i; break; end
      if (i == 3 && with_done) begin
        bus.core_done = 1'b1;
        bus.core_res  = pack_resvec();
      end
    end
    bus.core_done = 1'b0;
    chk({tag, " ack latency"}, lat, 4);
    chk({tag, " core_start"}, bus.core_start, exp_start);
    check_all(tag);
  endtask

  // Standalone completion pulse (called at a falling edge)
  task automatic pulse_done(input string tag);
    bus.core_done = 1'b1;
    bus.core_res  = pack_resvec();
    @(negedge clk);
    bus.core_done = 1'b0;
    if (m_busy) begin
      for (int i = 0; i < RES_WORDS; i++) m_res[i] = res_vec[i];
      m_busy = 0; m_done = 1; m_stat = 16'hAB51;
    end
    check_all(tag);
  endtask

  initial begin
    logic [7:0]  a;
    logic [31:0] wd;

    // Reset state
    rst = 1'b1;
    drive_idle();
    model_reset();
    repeat (3) @(negedge clk);
    check_all("reset");
    chk("reset core_start", bus.core_start, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Directed vector table
    tbl[0]  = '{2'd1, 8'h03, 32'h12345678, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{2'd3, 8'h03, 32'h0,        1'b0, 32'h12345678, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{2'd3, 8'h40, 32'h0,        1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{2'd0, 8'h00, 32'h0,        1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{2'd1, 8'h0C, 32'h1,        1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{2'd2, 8'h00, 32'h0,        1'b0, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{2'd2, 8'h00, 32'h0,        1'b0, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{2'd1, 8'h00, 32'h0000AAAA, 1'b0, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{2'd3, 8'h00, 32'h0,        1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{2'd3, 8'h80, 32'h0,        1'b1, 32'h00000000, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{2'd3, 8'h80, 32'h0,        1'b0, 32'hCAFEF00D, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{2'd2, 8'h00, 32'h0,        1'b0, 32'hCAFEF00D, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{2'd2, 8'h00, 32'h0,        1'b1, 32'hCAFEF00D, 1'b1, 1'b0, 1'b1};
    tbl[13] = '{2'd3, 8'h8B, 32'h0,        1'b0, 32'h5000000B, 1'b0, 1'b0, 1'b1};
    res_vec[0] = 32'hCAFEF00D;
    for (int i = 1; i < RES_WORDS; i++) res_vec[i] = 32'h50000000 + i;
    for (int n = 0; n < 14; n++) begin
      do_cmd(tbl[n].k, tbl[n].a, tbl[n].wd, tbl[n].dn, $sformatf("tbl%0d", n));
      chk($sformatf("tbl%0d rdata", n), bus.la_data_out[31:0], tbl[n].rd);
      chk($sformatf("tbl%0d err", n),   bus.la_data_out[67], tbl[n].er);
      chk($sformatf("tbl%0d busy", n),  bus.la_data_out[65], tbl[n].bz);
      chk($sformatf("tbl%0d done", n),  bus.la_data_out[66], tbl[n].dq);
    end

    // Fill all operands, run, complete, read result word 0
    for (int i = 0; i < OP_WORDS; i++) do_cmd(2'd1, 8'(i), $urandom, 1'b0, "fill");
    do_cmd(2'd2, 8'h00, 32'h0, 1'b0, "run start");
    rand_res();
    res_vec[0] = 32'hCAFEF00D;
    pulse_done("run done");
    do_cmd(2'd3, 8'h80, 32'h0, 1'b0, "run read");
    chk("run result word0", bus.la_data_out[31:0], 32'hCAFEF00D);

    // req toggle ignored while la_oenb[64] is high, and no ghost on release
    bus.la_oenb[64] = 1'b1;
    req = ~req;
    bus.la_data_in[64] = req;
    repeat (8) @(negedge clk);
    check_all("oenb high");
    bus.la_oenb[64] = 1'b0;
    repeat (8) @(negedge clk);
    check_all("oenb release");

    // Reset two cycles into an operation, then a late completion
    do_cmd(2'd2, 8'h00, 32'h0, 1'b0, "mid start");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    drive_idle();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_all("mid reset");
    rand_res();
    pulse_done("late done");
    repeat (4) @(negedge clk);
    chk("start pulse count after reset", start_cnt, m_starts);

    // Randomized commands against the model
    for (int n = 0; n < 450; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        rand_res();
        pulse_done("rnd done");
      end else begin
        case ($urandom_range(0, 2))
          0:       a = 8'($urandom_range(0, 11));
          1:       a = 8'h80 + 8'($urandom_range(0, 11));
          default: a = 8'($urandom_range(0, 255));
        endcase
        wd = $urandom;
        rand_res();
        do_cmd(2'($urandom_range(0, 3)), a, wd, ($urandom_range(0, 3) == 0), "rnd");
      end
    end
    repeat (2) @(negedge clk);
    chk("start pulse count", start_cnt, m_starts);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
